// File: rtl/top_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, byte held on o_RX with DV strobe.
// Optional stop-bit frame-error checking and o_RX_err port when UART_RX_FRAME_ERR_EN is defined.
module top_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_Rx_serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       o_RX_err
`endif
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntBitEnd = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf   = CntW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StCleanup
    } state_e;

    logic            rx_meta_q;
    logic            rx_sync_q;
    state_e          state_q;
    logic [CntW-1:0] clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            o_RX      <= 8'h00;
            o_RX_DV   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            o_RX_err  <= 1'b0;
`endif
        end else begin
            o_RX_DV  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            o_RX_err <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (!rx_sync_q) state_q <= StStart;
                end
                StStart: begin
                    if (clk_cnt_q == CntHalf) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        // A high line at mid start bit was a glitch.
                        state_q   <= rx_sync_q ? StIdle : StData;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (clk_cnt_q != CntBitEnd) begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end else begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_sync_q;
                        if (bit_idx_q == 3'd7) state_q <= StStop;
                        else bit_idx_q <= bit_idx_q + 1'b1;
                    end
                end
                StStop: begin
                    if (clk_cnt_q != CntBitEnd) begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end else begin
                        clk_cnt_q <= '0;
                        state_q   <= StCleanup;
`ifdef UART_RX_FRAME_ERR_EN
                        if (!rx_sync_q) begin
                            o_RX_err <= 1'b1;
                        end else begin
                            o_RX    <= shift_q;
                            o_RX_DV <= 1'b1;
                        end
`else
                        o_RX    <= shift_q;
                        o_RX_DV <= 1'b1;
`endif
                    end
                end
                StCleanup: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_top_uart_rx.sv
// Bench for top_uart_rx: directed board-rate frames, a table of short-rate frames, and random
// frames checked against a byte-queue model. Frame-error cases follow UART_RX_FRAME_ERR_EN.
module tb_top_uart_rx;

    localparam int unsigned FastCpb = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_s = 1'b1;
    logic       rx_f = 1'b1;
    logic       dv_s, dv_f;
    logic [7:0] out_s, out_f;
`ifdef UART_RX_FRAME_ERR_EN
    logic       err_s, err_f;
`endif

    int checks = 0;
    int errors = 0;
    int dv_cnt_s = 0;
    int dv_cnt_f = 0;
    int err_cnt_f = 0;
    logic prev_dv_s = 1'b0;
    logic prev_dv_f = 1'b0;
    logic [7:0] got_s[$];
    logic [7:0] got_f[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         start_cyc;
        bit         stop_val;
        bit         exp_dv;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    top_uart_rx dut_s (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_Rx_serial (rx_s),
        .o_RX_DV     (dv_s),
        .o_RX        (out_s)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .o_RX_err    (err_s)
`endif
    );

    top_uart_rx #(.CLKS_PER_BIT(FastCpb)) dut_f (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_Rx_serial (rx_f),
        .o_RX_DV     (dv_f),
        .o_RX        (out_f)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .o_RX_err    (err_f)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dv_s) begin
            check("dv_s_one_cycle", 32'(prev_dv_s), 32'd0);
            got_s.push_back(out_s);
            dv_cnt_s++;
        end
        if (dv_f) begin
            check("dv_f_one_cycle", 32'(prev_dv_f), 32'd0);
            got_f.push_back(out_f);
            dv_cnt_f++;
        end
        prev_dv_s = dv_s;
        prev_dv_f = dv_f;
`ifdef UART_RX_FRAME_ERR_EN
        if (err_f) err_cnt_f++;
`endif
    end

    task automatic wait_cyc(input int n);
        repeat (n) #10;
    endtask

    task automatic drive(input bit fast, input bit v);
        if (fast) rx_f = v;
        else rx_s = v;
    endtask

    task automatic send(input bit fast, input logic [7:0] data, input int bit_cyc,
                        input int start_cyc, input bit stop_val);
        drive(fast, 1'b0);
        wait_cyc(start_cyc);
        for (int i = 0; i < 8; i++) begin
            drive(fast, data[i]);
            wait_cyc(bit_cyc);
        end
        drive(fast, stop_val);
        wait_cyc(bit_cyc);
        drive(fast, 1'b1);
    endtask

    initial begin
        int base_s, base_f, base_q, base_e;
        logic [7:0] model_rx;
        logic [7:0] a5;
        bit accept;

        vecs[0] = '{8'h00, 16, 1'b1, 1'b1, 8'h00};
        vecs[1] = '{8'hFF, 17, 1'b1, 1'b1, 8'hFF};
        vecs[2] = '{8'h55, 18, 1'b1, 1'b1, 8'h55};
        vecs[3] = '{8'hAA, 16, 1'b1, 1'b1, 8'hAA};
        vecs[4] = '{8'h01, 18, 1'b1, 1'b1, 8'h01};
        vecs[5] = '{8'h80, 16, 1'b1, 1'b1, 8'h80};
        vecs[6] = '{8'hC3, 17, 1'b1, 1'b1, 8'hC3};
`ifdef UART_RX_FRAME_ERR_EN
        vecs[7] = '{8'h7E, 16, 1'b0, 1'b0, 8'hC3};
`else
        vecs[7] = '{8'h7E, 16, 1'b0, 1'b1, 8'h7E};
`endif

        #6;
        wait_cyc(4);
        check("reset_rx_s", 32'(out_s), 32'h00);
        check("reset_dv_s", 32'(dv_s), 32'd0);
        check("reset_rx_f", 32'(out_f), 32'h00);
        rst = 1'b0;

        wait_cyc(20000);
        check("idle_dv_count", dv_cnt_s, 0);
        check("idle_rx", 32'(out_s), 32'h00);

        // 8600 ns bits with a 9600 ns start bit against an 8680 ns nominal bit.
        send(1'b0, 8'h56, 860, 960, 1'b1);
        check("b56_dv_count", dv_cnt_s, 1);
        check("b56_rx", 32'(out_s), 32'h56);
        send(1'b0, 8'h48, 860, 960, 1'b1);
        check("b2b_dv_count", dv_cnt_s, 2);
        check("b2b_first", 32'(got_s.size() > 0 ? got_s[0] : 8'hxx), 32'h56);
        check("b2b_second", 32'(got_s.size() > 1 ? got_s[1] : 8'hxx), 32'h48);
        wait_cyc(500);
        check("b2b_hold", 32'(out_s), 32'h48);

        base_s = dv_cnt_s;
        drive(1'b0, 1'b0);
        wait_cyc(200);
        drive(1'b0, 1'b1);
        wait_cyc(1000);
        check("glitch_no_dv", dv_cnt_s - base_s, 0);
        check("glitch_rx_held", 32'(out_s), 32'h48);

        // Abort 0xA5 halfway through data bit 4.
        a5 = 8'hA5;
        drive(1'b0, 1'b0);
        wait_cyc(960);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, a5[i]);
            wait_cyc(860);
        end
        drive(1'b0, a5[4]);
        wait_cyc(430);
        rst = 1'b1;
        drive(1'b0, 1'b1);
        wait_cyc(5);
        check("rst_mid_rx", 32'(out_s), 32'h00);
        rst = 1'b0;
        wait_cyc(2000);
        check("rst_mid_no_dv", dv_cnt_s - base_s, 0);
        check("rst_mid_rx_after", 32'(out_s), 32'h00);
        send(1'b0, 8'h3C, 860, 960, 1'b1);
        wait_cyc(100);
        check("after_rst_dv", dv_cnt_s - base_s, 1);
        check("after_rst_rx", 32'(out_s), 32'h3C);

        for (int i = 0; i < 8; i++) begin
            base_f = dv_cnt_f;
            send(1'b1, vecs[i].data, FastCpb, vecs[i].start_cyc, vecs[i].stop_val);
            wait_cyc(2 * FastCpb);
            check($sformatf("vec%0d_dv", i), dv_cnt_f - base_f, 32'(vecs[i].exp_dv));
            check($sformatf("vec%0d_rx", i), 32'(out_f), 32'(vecs[i].exp_rx));
        end

        model_rx = vecs[7].exp_rx;
        base_q = got_f.size();
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            bit stop;
            d = 8'($urandom);
            stop = ($urandom_range(7, 0) != 0);
`ifdef UART_RX_FRAME_ERR_EN
            accept = stop;
`else
            accept = 1'b1;
`endif
            if (accept) begin
                exp_q.push_back(d);
                model_rx = d;
            end
            send(1'b1, d, FastCpb, int'($urandom_range(18, 16)), stop);
            wait_cyc(stop ? int'($urandom_range(20, 0)) : 32 + int'($urandom_range(10, 0)));
        end
        wait_cyc(40);
        check("rand_count", got_f.size() - base_q, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_q + i < got_f.size())
                check($sformatf("rand_byte%0d", i), 32'(got_f[base_q + i]), 32'(exp_q[i]));
        end
        check("rand_rx_last", 32'(out_f), 32'(model_rx));

`ifdef UART_RX_FRAME_ERR_EN
        base_f = dv_cnt_f;
        base_e = err_cnt_f;
        send(1'b1, 8'h81, FastCpb, FastCpb, 1'b0);
        wait_cyc(2 * FastCpb);
        check("ferr_pulse", err_cnt_f - base_e, 1);
        check("ferr_no_dv", dv_cnt_f - base_f, 0);
        check("ferr_rx_held", 32'(out_f), 32'(model_rx));
`else
        base_e = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
